// File: rtl/ultrasound_cnt_clk_drp_reconfig.sv
// Runtime DRP reconfiguration controller for the ultrasound counter-clock MMCM.
// Rewrites a table of DRP registers by read-modify-write while holding the MMCM in reset,
// then releases reset and waits for LOCKED. Any DRP or lock timeout ends the run with error.
module ultrasound_cnt_clk_drp_reconfig #(
  parameter int unsigned NUM_ENTRIES     = 2,
  parameter int unsigned RST_HOLD_CYCLES = 4,
  parameter int unsigned DRDY_TIMEOUT    = 255,
  parameter int unsigned LOCK_TIMEOUT    = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_ENTRIES*7-1:0]  cfg_addr,
  input  logic [NUM_ENTRIES*16-1:0] cfg_data,
  input  logic [NUM_ENTRIES*16-1:0] cfg_mask,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      mmcm_rst,
  output logic [6:0]                daddr,
  output logic                      den,
  output logic                      dwe,
  output logic [15:0]               di,
  input  logic [15:0]               do_i,
  input  logic                      drdy,
  input  logic                      mmcm_locked
);

  // One shared counter serves the reset hold and both kinds of timeout wait.
  localparam int unsigned CntMax0 = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned CntMax  = (RST_HOLD_CYCLES > CntMax0) ? RST_HOLD_CYCLES : CntMax0;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned IdxW    = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(RST_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] DrdyLast = CntW'(DRDY_TIMEOUT - 1);
  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRstHold,
    StRd,
    StRdWait,
    StWr,
    StWrWait,
    StRelease,
    StLockWait
  } state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [15:0]               di_q, di_d;
  logic                      error_q, error_d;
  logic                      done_q, done_d;
  logic [NUM_ENTRIES*7-1:0]  addr_tab_q, addr_tab_d;
  logic [NUM_ENTRIES*16-1:0] data_tab_q, data_tab_d;
  logic [NUM_ENTRIES*16-1:0] mask_tab_q, mask_tab_d;

  logic [6:0]  cur_addr;
  logic [15:0] cur_data;
  logic [15:0] cur_mask;

  assign cur_addr = addr_tab_q[idx_q*7 +: 7];
  assign cur_data = data_tab_q[idx_q*16 +: 16];
  assign cur_mask = mask_tab_q[idx_q*16 +: 16];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      di_q       <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      addr_tab_q <= '0;
      data_tab_q <= '0;
      mask_tab_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      di_q       <= di_d;
      error_q    <= error_d;
      done_q     <= done_d;
      addr_tab_q <= addr_tab_d;
      data_tab_q <= data_tab_d;
      mask_tab_q <= mask_tab_d;
    end
  end

  // Next-state: sequencing, timeouts, table latch and merged write data
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    di_d       = di_q;
    error_d    = error_q;
    done_d     = 1'b0;
    addr_tab_d = addr_tab_q;
    data_tab_d = data_tab_q;
    mask_tab_d = mask_tab_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRstHold;
          cnt_d      = '0;
          idx_d      = '0;
          error_d    = 1'b0;
          addr_tab_d = cfg_addr;
          data_tab_d = cfg_data;
          mask_tab_d = cfg_mask;
        end
      end
      StRstHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StRd;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRd: begin
        state_d = StRdWait;
        cnt_d   = '0;
      end
      StRdWait: begin
        if (drdy) begin
          // Mask bits set keep the current MMCM value; cleared bits take the new value.
          di_d    = (do_i & cur_mask) | (cur_data & ~cur_mask);
          state_d = StWr;
        end else if (cnt_q == DrdyLast) begin
          state_d = StIdle;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWr: begin
        state_d = StWrWait;
        cnt_d   = '0;
      end
      StWrWait: begin
        if (drdy) begin
          if (idx_q == IdxLast) begin
            state_d = StRelease;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StRd;
          end
        end else if (cnt_q == DrdyLast) begin
          state_d = StIdle;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        state_d = StLockWait;
        cnt_d   = '0;
      end
      StLockWait: begin
        if (mmcm_locked) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (cnt_q == LockLast) begin
          state_d = StIdle;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; done/error/di come straight from registers
  always_comb begin
    busy     = 1'b1;
    mmcm_rst = 1'b0;
    den      = 1'b0;
    dwe      = 1'b0;
    daddr    = '0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StRstHold, StRdWait, StWrWait: mmcm_rst = 1'b1;
      StRd: begin
        mmcm_rst = 1'b1;
        den      = 1'b1;
        daddr    = cur_addr;
      end
      StWr: begin
        mmcm_rst = 1'b1;
        den      = 1'b1;
        dwe      = 1'b1;
        daddr    = cur_addr;
      end
      StRelease, StLockWait: mmcm_rst = 1'b0;
      default: busy = 1'b0;
    endcase
  end

  assign done  = done_q;
  assign error = error_q;
  assign di    = di_q;

endmodule
